ksa_controller: RTL

Sequencing controller for the RC4 key-scheduling algorithm (KSA). It owns the single-port 256x8 S-box memory (`s_memory`). It first initialises the memory with `s[i] = i`, then runs the 256-iteration swap loop `j = j + s[i] + key[i mod KEY_LEN]; swap(s[i], s[j])`. It sits between the top-level `ksa` wrapper, which supplies start/key from switches and keys, and the memory instance. It replaces the free-running address counter with a start/busy/done handshake.

---
 rtl/ksa_controller_if.sv | 32 +++
 rtl/ksa_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ksa_controller_if.sv
// ============================================================================
//  ksa_controller_if : start/key handshake and S-box memory bus of the KSA
//  controller. Revision 1.0
// ============================================================================
`default_nettype none

interface ksa_controller_if #(
    parameter int KEY_LEN = 3
);
    logic                   start;
    logic [KEY_LEN*8-1:0]   secret_key;
    logic                   busy;
    logic                   done;
    logic [7:0]             mem_addr;
    logic [7:0]             mem_wrdata;
    logic                   mem_wren;
    logic [7:0]             mem_rddata;

    // master: the controller, which drives the memory bus and status
    modport master (
        input  start, secret_key, mem_rddata,
        output busy, done, mem_addr, mem_wrdata, mem_wren
    );

    // slave: wrapper plus memory, which supply start/key and read data
    modport slave (
        output start, secret_key, mem_rddata,
        input  busy, done, mem_addr, mem_wrdata, mem_wren
    );
endinterface

`default_nettype wire

// File: rtl/ksa_controller.sv
// ============================================================================
//  ksa_controller : RC4 key-scheduling sequencer driving a 256x8 single-port
//  S-box memory (fill s[i]=i, then the 256-iteration swap loop).
//  Revision 1.0
// ============================================================================
`default_nettype none

module ksa_controller #(
    parameter int KEY_LEN = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    ksa_controller_if.master    bus
);

    localparam int            KW     = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int            KN     = 1 << KW;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        RD_I   = 4'd2,
        LAT_I  = 4'd3,
        CALC_J = 4'd4,
        RD_J   = 4'd5,
        LAT_J  = 4'd6,
        WR_I   = 4'd7,
        WR_J   = 4'd8,
        DRAIN  = 4'd9,
        FIN    = 4'd10
    } state_t;

    state_t                 state;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [KW-1:0]          k;
    logic [7:0]             si;
    logic [7:0]             sj;
    logic [KEY_LEN*8-1:0]   key_r;
    logic [7:0]             key_bytes [KN];
    logic [7:0]             j_next;

    // key[0] is the most significant byte; unused slots of the
    // power-of-two table read as zero and are never selected
    generate
        for (genvar n = 0; n < KN; n++) begin : g_key
            if (n < KEY_LEN) begin : g_byte
                assign key_bytes[n] = key_r[(KEY_LEN-1-n)*8 +: 8];
            end else begin : g_pad
                assign key_bytes[n] = 8'h00;
            end
        end
    endgenerate

    assign j_next = j + si + key_bytes[k];

    // Outputs are registered: each transition loads the bus values for the
    // state being entered, so the memory sees them during that state's cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            i              <= 8'd0;
            j              <= 8'd0;
            k              <= '0;
            si             <= 8'd0;
            sj             <= 8'd0;
            key_r          <= '0;
            bus.mem_addr   <= 8'd0;
            bus.mem_wrdata <= 8'd0;
            bus.mem_wren   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state          <= INIT;
                        key_r          <= bus.secret_key;
                        i              <= 8'd0;
                        j              <= 8'd0;
                        k              <= '0;
                        bus.mem_addr   <= 8'd0;
                        bus.mem_wrdata <= 8'd0;
                        bus.mem_wren   <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                    end
                end
                INIT: begin
                    if (i == 8'hFF) begin
                        state          <= RD_I;
                        i              <= 8'd0;
                        bus.mem_addr   <= 8'd0;
                        bus.mem_wrdata <= 8'd0;
                        bus.mem_wren   <= 1'b0;
                    end else begin
                        i              <= i + 8'd1;
                        bus.mem_addr   <= i + 8'd1;
                        bus.mem_wrdata <= i + 8'd1;
                    end
                end
                RD_I: begin
                    state <= LAT_I;
                end
                LAT_I: begin
                    si    <= bus.mem_rddata;
                    state <= CALC_J;
                end
                CALC_J: begin
                    j            <= j_next;
                    bus.mem_addr <= j_next;
                    state        <= RD_J;
                end
                RD_J: begin
                    state <= LAT_J;
                end
                LAT_J: begin
                    sj             <= bus.mem_rddata;
                    bus.mem_addr   <= i;
                    bus.mem_wrdata <= bus.mem_rddata;
                    bus.mem_wren   <= 1'b1;
                    state          <= WR_I;
                end
                WR_I: begin
                    bus.mem_addr   <= j;
                    bus.mem_wrdata <= si;
                    state          <= WR_J;
                end
                WR_J: begin
                    bus.mem_wren   <= 1'b0;
                    bus.mem_wrdata <= 8'd0;
                    i              <= i + 8'd1;
                    k              <= (k == K_LAST) ? '0 : k + KW'(1);
                    if (i == 8'hFF) begin
                        state        <= DRAIN;
                        bus.mem_addr <= 8'd0;
                    end else begin
                        state        <= RD_I;
                        bus.mem_addr <= i + 8'd1;
                    end
                end
                // one quiet cycle after the final swap write before done
                DRAIN: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= FIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_wr_i_data: assert property (@(posedge clk) disable iff (!reset_n)
        (state == WR_I) |-> (bus.mem_wren && bus.mem_wrdata == sj));

    a_wren_states: assert property (@(posedge clk) disable iff (!reset_n)
        bus.mem_wren |-> (state == INIT || state == WR_I || state == WR_J));

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.busy && bus.done));

endmodule

`default_nettype wire
